// File: rtl/char_buffer_ram.sv
// COLS x ROWS character-map RAM for the text overlay: registered read port,
// cursor write port with wrap/newline handling, and a full-screen clear sequencer.
module char_buffer_ram #(
  parameter  int                COLS       = 16,
  parameter  int                ROWS       = 16,
  parameter  int                CODE_W     = 7,
  parameter  logic [CODE_W-1:0] BLANK_CODE = CODE_W'(7'h20),
  parameter  logic [CODE_W-1:0] NL_CODE    = CODE_W'(7'h7f),
  localparam int                CW         = $clog2(COLS),
  localparam int                RW         = $clog2(ROWS),
  localparam int                AW         = CW + RW,
  localparam int                N          = COLS * ROWS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rd_xy,
  output logic [CODE_W-1:0] rd_code,
  input  logic              cur_set,
  input  logic [AW-1:0]     cur_xy,
  input  logic              wr_valid,
  input  logic [CODE_W-1:0] wr_code,
  output logic              wr_ready,
  input  logic              clr_req,
  output logic              busy,
  output logic [AW-1:0]     cur_pos
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_addr_q;
  logic [AW-1:0]     cursor_q;
  logic [AW-1:0]     eff_xy;
  logic [AW-1:0]     wr_addr;
  logic [CODE_W-1:0] wr_data;
  logic              wr_en;
  logic              wr_acc;
  logic              clr_last;
  logic [CODE_W-1:0] rd_code_p1;
  logic [CODE_W-1:0] mem [N];

  // Newline moves to column 0 of the next row; anything else advances one cell.
  function automatic logic [AW-1:0] next_cursor(input logic [AW-1:0] e, input logic nl);
    logic [RW-1:0] row;
    row = e[AW-1:CW] + RW'(1);
    if (nl) return {row, {CW{1'b0}}};
    return e + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clr_req)  state_d = S_CLEAR;
      S_CLEAR: if (clr_last) state_d = S_IDLE;
      default: state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    busy     = (state_q == S_CLEAR);
    wr_ready = (state_q == S_IDLE);
  end

  assign clr_last = (clr_addr_q == AW'(N - 1));
  assign wr_acc   = wr_valid && wr_ready;
  assign eff_xy   = cur_set ? cur_xy : cursor_q;

  // Address counter rolls over to 0 on its own after N-1 and stays 0 while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     clr_addr_q <= '0;
    else if (busy)  clr_addr_q <= clr_addr_q + AW'(1);
    else            clr_addr_q <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_q <= '0;
    end else if (busy) begin
      if (clr_last) cursor_q <= '0;
    end else if (wr_acc) begin
      cursor_q <= next_cursor(eff_xy, wr_code == NL_CODE);
    end else if (cur_set) begin
      cursor_q <= cur_xy;
    end
  end

  assign cur_pos = cursor_q;

  always_comb begin
    wr_addr = eff_xy;
    wr_data = wr_code;
    wr_en   = wr_acc && (wr_code != NL_CODE);
    if (busy) begin
      wr_addr = clr_addr_q;
      wr_data = BLANK_CODE;
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Stage p1: synchronous read, read-first against a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_code_p1 <= '0;
    else        rd_code_p1 <= mem[rd_xy];
  end

  assign rd_code = rd_code_p1;

endmodule

// File: tb/tb_char_buffer_ram.sv
// Randomized and directed bench for char_buffer_ram against a cell-array reference model.
module tb_char_buffer_ram;

  localparam int        COLS = 16;
  localparam int        ROWS = 16;
  localparam int        N    = COLS * ROWS;
  localparam logic [6:0] BL  = 7'h20;
  localparam logic [6:0] NL  = 7'h7f;
  localparam logic [6:0] CH_G = 7'h47, CH_R = 7'h52, CH_A = 7'h41, CH_X = 7'h58,
                         CH_Y = 7'h59, CH_M = 7'h4d, CH_Z = 7'h5a, CH_Q = 7'h51,
                         CH_K = 7'h4b;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rd_xy = '0;
  logic [6:0] rd_code;
  logic       cur_set = 1'b0;
  logic [7:0] cur_xy = '0;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_code = '0;
  logic       wr_ready;
  logic       clr_req = 1'b0;
  logic       busy;
  logic [7:0] cur_pos;

  char_buffer_ram #(.COLS(COLS), .ROWS(ROWS), .CODE_W(7), .BLANK_CODE(BL), .NL_CODE(NL)) dut (
    .clk(clk), .rst_n(rst_n), .rd_xy(rd_xy), .rd_code(rd_code), .cur_set(cur_set),
    .cur_xy(cur_xy), .wr_valid(wr_valid), .wr_code(wr_code), .wr_ready(wr_ready),
    .clr_req(clr_req), .busy(busy), .cur_pos(cur_pos)
  );

  always #5 clk = ~clk;

  logic [6:0] m_mem [N];
  bit         m_known [N];
  int         m_clr;
  int         m_cur;
  logic [6:0] m_rd;
  bit         m_rd_known;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    m_clr = N;
    m_cur = 0;
    m_rd = '0;
    m_rd_known = 1'b1;
  endtask

  task automatic model_edge();
    int e, a;
    m_rd = m_mem[rd_xy];
    m_rd_known = m_known[rd_xy];
    if (m_clr > 0) begin
      a = N - m_clr;
      m_mem[a] = BL;
      m_known[a] = 1'b1;
      m_clr--;
      if (m_clr == 0) m_cur = 0;
    end else begin
      e = cur_set ? int'(cur_xy) : m_cur;
      if (wr_valid) begin
        if (wr_code == NL) m_cur = (((e / COLS) + 1) % ROWS) * COLS;
        else begin
          m_mem[e] = wr_code;
          m_known[e] = 1'b1;
          m_cur = (e + 1) % N;
        end
      end else if (cur_set) begin
        m_cur = cur_xy;
      end
      if (clr_req) m_clr = N;
    end
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_clr != 0);
    chk("wr_ready", wr_ready, m_clr == 0);
    chk("cur_pos", cur_pos, m_cur);
    if (m_rd_known) chk("rd_code", rd_code, m_rd);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    check_outputs();
  endtask

  task automatic idle_in();
    cur_set = 1'b0;
    wr_valid = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rd_code", rd_code, 0);
    chk("rst_busy", busy, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_cur_pos", cur_pos, 0);
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_clear(input int want, input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 1000) begin
      step();
      cnt++;
    end
    chk(tag, cnt, want);
  endtask

  task automatic read_all_blank();
    for (int a = 0; a < N; a++) begin
      rd_xy = 8'(a);
      step();
      chk("blank_cell", rd_code, BL);
    end
  endtask

  task automatic write1(input logic set, input logic [7:0] xy, input logic [6:0] code);
    cur_set = set;
    cur_xy = xy;
    wr_valid = 1'b1;
    wr_code = code;
    step();
    idle_in();
  endtask

  task automatic read1(input logic [7:0] xy, input logic [6:0] want, input string tag);
    rd_xy = xy;
    step();
    chk(tag, rd_code, want);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_known[i] = 1'b0;
    #2;
    apply_reset(3);
    wait_clear(256, "init_clear_len");
    chk("init_cur_pos", cur_pos, 0);
    chk("init_wr_ready", wr_ready, 1);
    read_all_blank();

    write1(1'b1, 8'h05, CH_G);
    write1(1'b0, 8'h00, CH_R);
    write1(1'b0, 8'h00, CH_A);
    chk("gra_cur_pos", cur_pos, 8'h08);
    read1(8'h05, CH_G, "cell_05");
    read1(8'h06, CH_R, "cell_06");
    read1(8'h07, CH_A, "cell_07");

    write1(1'b1, 8'hff, CH_X);
    write1(1'b0, 8'h00, CH_Y);
    chk("wrap_cur_pos", cur_pos, 8'h01);
    read1(8'hff, CH_X, "cell_ff");
    read1(8'h00, CH_Y, "cell_00");

    write1(1'b1, 8'h13, NL);
    chk("nl_cur_pos", cur_pos, 8'h20);
    read1(8'h13, BL, "nl_no_store");
    write1(1'b1, 8'hf4, NL);
    chk("nl_wrap_cur_pos", cur_pos, 8'h00);

    write1(1'b1, 8'h10, CH_M);
    rd_xy = 8'h10;
    write1(1'b1, 8'h10, CH_Z);
    chk("collide_old", rd_code, CH_M);
    step();
    chk("collide_new", rd_code, CH_Z);

    cur_set = 1'b1; cur_xy = 8'h30; wr_valid = 1'b1; wr_code = CH_Q; clr_req = 1'b1;
    step();
    chk("clr_entry_busy", busy, 1);
    cur_set = 1'b0; clr_req = 1'b0; wr_code = CH_K; rd_xy = 8'h30;
    step();
    chk("clr_write_landed", rd_code, CH_Q);
    wait_clear(255, "clr_len");
    idle_in();
    chk("clr_cur_pos", cur_pos, 0);
    read_all_blank();

    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (100) step();
    apply_reset(2);
    wait_clear(256, "abort_clear_len");
    read_all_blank();

    for (int i = 0; i < 3000; i++) begin
      rd_xy    = 8'($urandom);
      cur_set  = ($urandom_range(0, 6) == 0);
      cur_xy   = 8'($urandom);
      wr_valid = $urandom_range(0, 1) == 1;
      wr_code  = ($urandom_range(0, 9) == 0) ? NL : 7'($urandom);
      clr_req  = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
